// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate generator for the ID stage, with a 2-entry skid buffer
// between IF/ID and ID/EX.
//   state | meaning
//   EMPTY | no entry held, out_valid_o=0
//   ONE   | main entry valid
//   FULL  | main and skid entries valid, in_ready_o=0
module imm_gen_pipe #(
  parameter int XLEN     = 32,
  parameter bit ZERO_ILL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ILL   = 3'd7;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;

  buf_state_t state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            shamt_op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  logic [XLEN-1:0] main_imm, skid_imm;
  logic [2:0]      main_fmt, skid_fmt;
  logic            main_ill, skid_ill;
  logic            in_xfer, out_xfer;
  logic            load_main, load_skid, move_skid;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign shamt_op = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = XLEN'($signed(instr_i[31:20]));
  assign imm_s = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (shamt_op) begin
          dec_fmt = FMT_SHAMT;
          dec_imm = (XLEN == 32) ? XLEN'(instr_i[24:20]) : XLEN'(instr_i[25:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = imm_i;
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          if (shamt_op) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(instr_i[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = imm_u;
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = imm_j;
      end
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: dec_ill = (XLEN != 64);
      default:    dec_ill = 1'b1;
    endcase
    // Illegal opcodes still carry an I-style immediate unless ZERO_ILL forces zero.
    if (dec_ill) begin
      dec_fmt = FMT_ILL;
      dec_imm = ZERO_ILL ? '0 : imm_i;
    end
  end

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign in_xfer     = in_valid_i && in_ready_o;
  assign out_xfer    = out_valid_o && out_ready_i;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          move_skid = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= EMPTY;
      main_imm <= '0;
      main_fmt <= FMT_R;
      main_ill <= 1'b0;
      skid_imm <= '0;
      skid_fmt <= FMT_R;
      skid_ill <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_imm <= dec_imm;
        main_fmt <= dec_fmt;
        main_ill <= dec_ill;
      end else if (move_skid) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_ill <= skid_ill;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_ill <= dec_ill;
      end
    end
  end

  assign imm_o     = main_imm;
  assign fmt_o     = main_fmt;
  assign illegal_o = main_ill;

endmodule
